// File: rtl/shot_multiplier_pkg.sv
// Shared encodings and helpers for the Shot consumer blocks.
// Holds the multiplier FSM state codes and the width helper used to size the counter.
package shot_multiplier_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/shot_multiplier_rise.sv
// Registered 0->1 detector for a level input.
// The reset value of the history bit decides whether a level already high at reset release counts as an edge.
module rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_rise
);

  logic r_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_d <= RST_VAL;
    else        r_d <= i_d;
  end

  assign o_rise = i_d & ~r_d;

endmodule

// File: rtl/shot_multiplier.sv
// Sequential shift-add unsigned multiplier launched by a rising edge of Shot.
// Retires one multiplier bit per clock; the product register is only written on completion.
module shot_multiplier
  import shot_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shot,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 ready
);

  localparam int unsigned CNT_W = clog2(WIDTH + 1);

  logic [1:0]           r_state;
  logic [2*WIDTH-1:0]   r_a;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_product;
  logic [WIDTH-1:0]     r_b;
  logic [CNT_W-1:0]     r_count;
  logic                 w_start;
  logic [2*WIDTH-1:0]   w_sum;

  rise_detect #(.RST_VAL(1'b1)) u_shot_rise (
    .clk    (clk),
    .reset  (reset),
    .i_d    (shot),
    .o_rise (w_start)
  );

  // Accumulator value after this iteration; also what lands in product on the last one.
  always_comb begin
    w_sum = r_acc;
    if (r_b[0]) w_sum = r_acc + r_a;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_a     <= {{WIDTH{1'b0}}, multiplicand};
            r_b     <= multiplier;
            r_acc   <= '0;
            r_count <= '0;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_acc   <= w_sum;
          r_a     <= r_a << 1;
          r_b     <= r_b >> 1;
          r_count <= r_count + 1'b1;
          if (r_count == CNT_W'(WIDTH - 1)) begin
            r_product <= w_sum;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign product = r_product;
  assign busy    = (r_state == ST_CALC);
  assign ready   = (r_state == ST_DONE);

endmodule

// File: tb/tb_shot_multiplier.sv
// Scoreboard bench for shot_multiplier (WIDTH=8): stimulus queues expected results,
// a negedge monitor checks product, completion cycle and busy length on every ready pulse.
module tb_shot_multiplier;

  logic        clk;
  logic        reset;
  logic        shot;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic [15:0] product;
  logic        busy;
  logic        ready;

  typedef struct packed {
    logic [15:0] prod;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  int unsigned n_vec;
  int unsigned n_err;
  int unsigned cyc;
  int unsigned busy_run;
  logic        busy_seen;
  logic [15:0] last_prod;

  shot_multiplier #(.WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .shot         (shot),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .ready        (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: decoupled from stimulus, runs on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      busy_run  = 0;
      last_prod = '0;
    end else begin
      if (busy) begin
        busy_seen = 1'b1;
        busy_run  = busy_run + 1;
        check("product_hold_while_busy", {16'd0, product}, {16'd0, last_prod});
      end
      if (ready) begin
        if (q.size() == 0) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("product", {16'd0, product}, {16'd0, e.prod});
          check("ready_cycle", cyc, e.cyc);
          check("busy_cycles", busy_run, 32'd8);
          last_prod = e.prod;
        end
        busy_run = 0;
      end
    end
  end

  // Caller sits just after a posedge; launch edge is the next posedge after shot rises.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    exp_t e;
    shot = 1'b0;
    @(posedge clk); #1;
    shot         = 1'b1;
    multiplicand = a;
    multiplier   = b;
    e.prod = exp;
    e.cyc  = cyc + 9;
    q.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      check("completion_timeout", q.size(), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    busy_seen    = 1'b0;
    busy_run     = 0;
    last_prod    = '0;
    reset        = 1'b0;
    shot         = 1'b1;
    multiplicand = '0;
    multiplier   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_product", {16'd0, product}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ready", {31'd0, ready}, 32'd0);

    // Shot already high at reset release must not launch.
    multiplicand = 8'd50;
    multiplier   = 8'd50;
    reset        = 1'b1;
    busy_seen    = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("no_launch_busy", {31'd0, busy_seen}, 32'd0);
    check("no_launch_product", {16'd0, product}, 32'd0);

    launch(8'd13, 8'd11, 16'd143);
    wait_done();
    launch(8'd255, 8'd255, 16'd65025);
    wait_done();
    launch(8'd0, 8'd200, 16'd0);
    wait_done();

    // Re-trigger and operand change mid-CALC are ignored.
    launch(8'd7, 8'd6, 16'd42);
    repeat (3) @(posedge clk);
    #1 shot = 1'b0;
    @(posedge clk);
    #1;
    shot         = 1'b1;
    multiplicand = 8'd3;
    multiplier   = 8'd3;
    wait_done();
    repeat (15) @(posedge clk);
    #1;
    check("no_relaunch_queue", q.size(), 32'd0);
    check("no_relaunch_product", {16'd0, product}, 32'd42);

    // Abort in the middle of CALC.
    launch(8'd9, 8'd9, 16'd81);
    repeat (4) @(posedge clk);
    #1;
    q.delete();
    reset = 1'b0;
    #1;
    check("abort_product", {16'd0, product}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_result", {16'd0, product}, 32'd0);
    launch(8'd2, 8'd3, 16'd6);
    wait_done();

    // Back-to-back at the minimum period: ready pulses 10 cycles apart.
    repeat (3) @(posedge clk);
    #1;
    launch(8'd5, 8'd5, 16'd25);
    repeat (9) @(posedge clk);
    #1;
    launch(8'd10, 8'd10, 16'd100);
    wait_done();
    repeat (4) @(posedge clk);
    #1;
    check("final_product", {16'd0, product}, 32'd100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
